// File: rtl/bit_clock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bit_clock_sequencer
// Purpose  : Sequences a divided serial bit clock for one sensor-bus
//            transaction: chip-select, lead half-period, nbits sclk periods
//            with sample/shift strobes, trail half-period, done pulse.
// Ports    : clk, rst_n       - system clock, async active-low reset
//            start, abort     - transaction request / synchronous cancel
//            div_cfg, nbits   - half-period length and bit count (latched)
//            busy, done, cs_n - transaction status and chip select
//            sclk             - registered bit clock
//            sample_stb       - pulse with each sclk leading edge
//            shift_stb        - pulse with each sclk trailing edge
//            bit_idx          - completed bit count
// Options  : SCLK_IDLE_HIGH_EN - when defined sclk idles high (leading edge
//            falling); otherwise sclk idles low.
// Revision : 1.0 - initial release
// ============================================================================
module bit_clock_sequencer #(
  parameter int CLK_PER_BIT = 200,
  parameter int DIV_W       = 16,
  parameter int NBITS_W     = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [DIV_W-1:0]   div_cfg,
  input  logic [NBITS_W-1:0] nbits,
  output logic               busy,
  output logic               done,
  output logic               cs_n,
  output logic               sclk,
  output logic               sample_stb,
  output logic               shift_stb,
  output logic [NBITS_W-1:0] bit_idx
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LEAD   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_TRAIL  = 2'd3;

  localparam logic [DIV_W-1:0]   c_default_half = DIV_W'(CLK_PER_BIT);
  localparam logic [DIV_W-1:0]   c_div_one      = DIV_W'(1);
  localparam logic [NBITS_W-1:0] c_bit_one      = NBITS_W'(1);

`ifdef SCLK_IDLE_HIGH_EN
  localparam logic c_sclk_idle = 1'b1;
`else
  localparam logic c_sclk_idle = 1'b0;
`endif

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [DIV_W-1:0]   r_half;
  logic [NBITS_W-1:0] r_nbits;
  logic [DIV_W-1:0]   r_cnt;
  logic               r_sclk;
  logic               r_sample;
  logic               r_shift;
  logic               r_done;
  logic [NBITS_W-1:0] r_bit_idx;

  logic w_tick;
  logic w_abort;
  logic w_start_ok;
  logic w_accept_run;
  logic w_lead_phase;
  logic w_last_bit;
  logic w_sample_nxt;
  logic w_shift_nxt;
  logic w_done_nxt;

  // Tick marks the last cycle of a half-period; only meaningful while running.
  assign w_tick       = (r_state != S_IDLE) && (r_cnt == (r_half - c_div_one));
  assign w_abort      = abort && (r_state != S_IDLE);
  assign w_start_ok   = (r_state == S_IDLE) && start && !abort;
  assign w_accept_run = w_start_ok && (nbits != '0);
  // sclk away from its idle level means the next ACTIVE toggle is a trailing edge.
  assign w_lead_phase = (r_sclk != c_sclk_idle);
  assign w_last_bit   = w_lead_phase && ((r_bit_idx + c_bit_one) == r_nbits);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept_run) w_state_nxt = S_LEAD;
      S_LEAD:   if (abort) w_state_nxt = S_IDLE;
                else if (w_tick) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (abort) w_state_nxt = S_IDLE;
                else if (w_tick && w_last_bit) w_state_nxt = S_TRAIL;
      S_TRAIL:  if (abort || w_tick) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: status decoded from state, strobe/done next values for the
  // output registers below.
  always_comb begin
    busy         = (r_state != S_IDLE);
    cs_n         = (r_state == S_IDLE);
    w_sample_nxt = 1'b0;
    w_shift_nxt  = 1'b0;
    w_done_nxt   = 1'b0;
    case (r_state)
      S_IDLE:   w_done_nxt   = w_start_ok && (nbits == '0);
      S_LEAD:   w_sample_nxt = w_tick && !abort;
      S_ACTIVE: begin
        w_sample_nxt = w_tick && !abort && !w_lead_phase;
        w_shift_nxt  = w_tick && !abort && w_lead_phase;
      end
      S_TRAIL:  w_done_nxt   = w_tick && !abort;
      default:  w_done_nxt   = 1'b0;
    endcase
  end

  // Datapath: latched configuration, half-period counter, registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_half    <= c_default_half;
      r_nbits   <= '0;
      r_cnt     <= '0;
      r_sclk    <= c_sclk_idle;
      r_sample  <= 1'b0;
      r_shift   <= 1'b0;
      r_done    <= 1'b0;
      r_bit_idx <= '0;
    end else begin
      r_sample <= w_sample_nxt;
      r_shift  <= w_shift_nxt;
      r_done   <= w_done_nxt;

      if (w_accept_run) begin
        r_half  <= (div_cfg == '0) ? c_default_half : div_cfg;
        r_nbits <= nbits;
      end

      if ((r_state == S_IDLE) || w_abort || w_tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_div_one;
      end

      // Every strobe coincides with an sclk toggle; abort forces idle level.
      if (w_abort) begin
        r_sclk <= c_sclk_idle;
      end else if (w_sample_nxt || w_shift_nxt) begin
        r_sclk <= ~r_sclk;
      end

      if (w_accept_run) begin
        r_bit_idx <= '0;
      end else if (w_shift_nxt) begin
        r_bit_idx <= r_bit_idx + c_bit_one;
      end
    end
  end

  assign done       = r_done;
  assign sclk       = r_sclk;
  assign sample_stb = r_sample;
  assign shift_stb  = r_shift;
  assign bit_idx    = r_bit_idx;

endmodule
`default_nettype wire

// File: tb/tb_bit_clock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_clock_sequencer
// Purpose  : Self-checking bench for bit_clock_sequencer. Expected outputs
//            come from a per-cycle timing model derived from the transaction
//            rules (toggle k at cycle 1+k*H, done at 1+(2n+1)*H).
// Ports    : none
// Options  : SCLK_IDLE_HIGH_EN - selects expected sclk idle level.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_clock_sequencer;

  localparam int CLK_PER_BIT = 200;
  localparam int DIV_W       = 16;
  localparam int NBITS_W     = 6;

`ifdef SCLK_IDLE_HIGH_EN
  localparam logic IDLE_LVL = 1'b1;
`else
  localparam logic IDLE_LVL = 1'b0;
`endif

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic [DIV_W-1:0]   div_cfg;
  logic [NBITS_W-1:0] nbits;
  logic               busy;
  logic               done;
  logic               cs_n;
  logic               sclk;
  logic               sample_stb;
  logic               shift_stb;
  logic [NBITS_W-1:0] bit_idx;

  int errors = 0;
  int checks = 0;

  bit_clock_sequencer #(
    .CLK_PER_BIT (CLK_PER_BIT),
    .DIV_W       (DIV_W),
    .NBITS_W     (NBITS_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .div_cfg    (div_cfg),
    .nbits      (nbits),
    .busy       (busy),
    .done       (done),
    .cs_n       (cs_n),
    .sclk       (sclk),
    .sample_stb (sample_stb),
    .shift_stb  (shift_stb),
    .bit_idx    (bit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int t, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},   0, busy,       0);
    chk({tag, "_done"},   0, done,       0);
    chk({tag, "_cs_n"},   0, cs_n,       1);
    chk({tag, "_sclk"},   0, sclk,       IDLE_LVL);
    chk({tag, "_sample"}, 0, sample_stb, 0);
    chk({tag, "_shift"},  0, shift_stb,  0);
    chk({tag, "_bitidx"}, 0, bit_idx,    0);
  endtask

  // Starts a transaction in the current cycle (cycle 0) and checks every
  // following cycle against the timing model.
  // noise: 0 quiet, 1 random start/config while running, 2 start at 5 and 10.
  task automatic run_txn(input int h_cfg, input int n, input int abort_at,
                         input int extra, input int noise);
    int   h, t_done, t_stop, last, m, k, e_bi, frozen_bi;
    logic e_busy, e_sclk, e_samp, e_shift, e_done, on_edge;
    h         = (h_cfg == 0) ? CLK_PER_BIT : h_cfg;
    t_done    = (n == 0) ? 1 : 1 + (2 * n + 1) * h;
    t_stop    = (abort_at != 0) ? abort_at + 1 : t_done;
    last      = t_stop + extra;
    frozen_bi = 0;
    start     = 1'b1;
    abort     = 1'b0;
    div_cfg   = DIV_W'(h_cfg);
    nbits     = NBITS_W'(n);
    for (int t = 1; t <= last; t++) begin
      @(posedge clk); #1;
      e_busy = 1'b0; e_sclk = IDLE_LVL; e_samp = 1'b0; e_shift = 1'b0;
      e_done = 1'b0; e_bi = -1;
      if (n == 0) begin
        e_done = (t == 1);
      end else if (abort_at != 0 && t >= t_stop) begin
        e_bi = frozen_bi;
      end else if (t >= t_done) begin
        e_done = (t == t_done);
        e_bi   = n;
      end else begin
        k       = (t - 1) / h;
        m       = (k > 2 * n) ? 2 * n : k;
        on_edge = ((t - 1) % h == 0) && (k >= 1) && (k <= 2 * n);
        e_busy  = 1'b1;
        e_sclk  = IDLE_LVL ^ ((m % 2) != 0);
        e_samp  = on_edge && ((k % 2) == 1);
        e_shift = on_edge && ((k % 2) == 0);
        e_bi    = m / 2;
        if (t == abort_at) frozen_bi = e_bi;
      end
      chk("busy",   t, busy,       e_busy);
      chk("cs_n",   t, cs_n,       !e_busy);
      chk("sclk",   t, sclk,       e_sclk);
      chk("sample", t, sample_stb, e_samp);
      chk("shift",  t, shift_stb,  e_shift);
      chk("done",   t, done,       e_done);
      if (e_bi >= 0) chk("bit_idx", t, bit_idx, e_bi);

      abort = (t == abort_at);
      if (noise == 1) begin
        start   = (t < t_stop) ? ($urandom_range(0, 3) == 0) : 1'b0;
        div_cfg = DIV_W'($urandom_range(0, 9));
        nbits   = NBITS_W'($urandom_range(0, 20));
      end else if (noise == 2) begin
        start = (t == 5) || (t == 10);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int h, n, ab, tdn;
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    div_cfg = '0;
    nbits   = '0;
    #12;
    chk_idle_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn(4, 8, 0, 4, 0);
    run_txn(0, 1, 0, 3, 0);
    run_txn(5, 0, 0, 10, 0);
    run_txn(3, 4, 20, 50, 0);
    run_txn(3, 4, 20, 0, 0);
    run_txn(3, 4, 0, 3, 0);
    run_txn(2, 2, 0, 10, 2);

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1; div_cfg = 16'd3; nbits = 6'd4;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("abort_wins_busy", 1, busy, 0);
    chk("abort_wins_done", 1, done, 0);
    @(posedge clk); #1;
    chk("abort_wins_busy2", 2, busy, 0);
    chk("abort_wins_cs_n", 2, cs_n, 1);

    for (int i = 0; i < 12; i++) begin
      h   = int'($urandom_range(1, 6));
      n   = int'($urandom_range(1, 10));
      tdn = 1 + (2 * n + 1) * h;
      ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, tdn - 1)) : 0;
      run_txn(h, n, ab, int'($urandom_range(0, 3)), 1);
    end

    // Asynchronous reset mid-ACTIVE
    start = 1'b1; div_cfg = 16'd4; nbits = 6'd8;
    for (int t = 1; t <= 20; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("pre_reset_busy", 20, busy, 1);
    #3 rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_reset");
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle_outputs("post_reset");

    run_txn(1, 3, 0, 2, 1);
    run_txn(4, 8, 0, 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bit_clock_sequencer.md
Name: bit_clock_sequencer

Overview:
Controller that sequences a divided serial bit clock for one sensor-bus transaction.
- On start: asserts chip-select, runs a lead half-period, then emits exactly nbits sclk periods with per-edge sample/shift strobes, a trail half-period, and a done pulse.
- Replaces free-running divider usage in the sensor front end; the serial shift register consumes its strobes.

Parameters:
CLK_PER_BIT, 200, default half-period in clk cycles, used when div_cfg is 0
DIV_W, 16, width of div_cfg and the internal half-period counter
NBITS_W, 6, width of nbits

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a transaction; accepted only in IDLE
abort  input  1  synchronous cancel of a running transaction
div_cfg  input  DIV_W  half-period length; latched on start accept; 0 selects CLK_PER_BIT
nbits  input  NBITS_W  number of bit periods; latched on start accept
busy  output  1  high from the cycle after start accept until the done cycle (exclusive)
done  output  1  one-cycle pulse at normal completion
cs_n  output  1  chip select, low while busy
sclk  output  1  bit clock, registered
sample_stb  output  1  one-cycle pulse coincident with each sclk leading edge
shift_stb  output  1  one-cycle pulse coincident with each sclk trailing edge
bit_idx  output  NBITS_W  completed bit count, incremented on each trailing edge

Behaviour:
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, cs_n=1, sclk=idle level (0), strobes=0, bit_idx=0, counters=0.
- H is the latched half-period: div_cfg if nonzero, else CLK_PER_BIT truncated to DIV_W.
- Half-period counter runs 0..H-1. Reaching H-1 is a "tick"; the counter returns to 0 on the tick.
- States: IDLE, LEAD, ACTIVE, TRAIL.
- Cycle numbering: start accept is at the edge closing cycle 0.
- IDLE with start=1, abort=0 and latched nbits!=0 -> LEAD.
  - Cycle 1 onward: busy=1, cs_n=0, bit_idx=0.
- IDLE with start=1 and nbits=0 -> stays IDLE.
  - done=1 in cycle 1 only; busy and cs_n unchanged; no sclk activity.
- LEAD: on tick -> ACTIVE. sclk makes toggle 1 (leading edge) with sample_stb=1 in that same output cycle.
- ACTIVE: each tick toggles sclk.
  - Toggle k occurs in cycle 1+k*H, for k=1..2*nbits.
  - Odd k is a leading edge: sample_stb pulses.
  - Even k is a trailing edge: shift_stb pulses and bit_idx increments.
  - After toggle 2*nbits -> TRAIL, with sclk at idle level.
- TRAIL: on tick -> IDLE.
  - Cycle 1+(2*nbits+1)*H: done=1, busy=0, cs_n=1.
  - bit_idx holds the final count until the next start accept.
- start while not IDLE: ignored. div_cfg and nbits changes after accept: ignored.
- abort=1 in any non-IDLE state -> IDLE at next edge.
  - busy=0, cs_n=1, sclk=idle, strobes=0, no done pulse; bit_idx holds.
  - abort and start both high in IDLE: abort wins, start not accepted.
- sample_stb and shift_stb are never high in the same cycle. done is never high while busy=1.
- H=1: one tick per cycle; sclk toggles every cycle; strobes alternate every cycle.

Optional Feature:
Macro SCLK_IDLE_HIGH_EN.
- Defined: sclk reset/idle level is 1. The leading edge is falling and the trailing edge is rising. Strobe timing is unchanged; only sclk polarity inverts.
- Undefined: sclk idles 0, leading edge rising.

Test Plan:
- Reset then div_cfg=4, nbits=8, start pulse at cycle 0:
  - busy=1 and cs_n=0 from cycle 1.
  - sclk toggles at cycles 5,9,...,65; sample_stb at 5,13,...,61; shift_stb at 9,17,...,65.
  - bit_idx=8 at 65; done only at cycle 69, busy=0 at 69.
- div_cfg=0 (CLK_PER_BIT=200), nbits=1: sclk rises at cycle 201, falls at 401; done at cycle 601.
- nbits=0 with start: done=1 at cycle 1 only; busy, cs_n and sclk never change.
- div_cfg=3, nbits=4, abort at cycle 20:
  - At cycle 21: busy=0, cs_n=1, sclk=0, bit_idx=3.
  - No done pulse over the next 50 cycles.
  - Second start at cycle 21 -> busy=1 at cycle 22, bit_idx=0.
- start re-pulsed at cycles 5 and 10 during a div_cfg=2, nbits=2 run: ignored. done occurs only at cycle 11, followed by no further activity.
- rst_n driven low mid-ACTIVE, asynchronously between edges: all outputs return to reset values immediately, without waiting for clk. With SCLK_IDLE_HIGH_EN defined, sclk=1 in reset and falls at cycle 5 in the first scenario.
